// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pin in, conditioned level and pulses out.
interface btn_conditioner_if;
  logic BTN_IN;
  logic BTN_LEVEL;
  logic BTN_PRESS;
  logic BTN_RELEASE;
  logic BTN_HELD;
  logic BTN_REPEAT;

  modport master (
    output BTN_IN,
    input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HELD, BTN_REPEAT
  );

  modport slave (
    input  BTN_IN,
    output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HELD, BTN_REPEAT
  );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises and debounces one push-button, producing a clean level plus
// press, release and hold/auto-repeat pulses.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic           CLK,
  input  logic           RST_N,
  btn_conditioner_if.slave btn
);

  localparam int unsigned MAX_A  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    HELD,
    DB_RELEASE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sync1, s;
  logic             level_q, level_n;
  logic             held_q, held_n;
  logic             press_q, press_n;
  logic             release_q, release_n;
  logic             repeat_q, repeat_n;

  // Two-flop synchroniser; the FSM only ever sees s.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn.BTN_IN;
      s     <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      level_q   <= 1'b0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_q   <= level_n;
      held_q    <= held_n;
      press_q   <= press_n;
      release_q <= release_n;
      repeat_q  <= repeat_n;
    end
  end

  // Next state, counter and registered-output values; counter clears on every entry.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    level_n   = level_q;
    held_n    = held_q;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (s) state_n = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n  = HELD;
          cnt_n    = '0;
          held_n   = 1'b1;
          repeat_n = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_n    = '0;
          repeat_n = 1'b1;
        end
      end
      DB_RELEASE: begin
        // A bounce back high resumes where we were; hold/repeat timing restarts.
        if (s) begin
          state_n = held_q ? HELD : PRESSED;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          held_n    = 1'b0;
          release_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign btn.BTN_LEVEL   = level_q;
  assign btn.BTN_PRESS   = press_q;
  assign btn.BTN_RELEASE = release_q;
  assign btn.BTN_HELD    = held_q;
  assign btn.BTN_REPEAT  = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=4, HOLD=20, REPEAT=8.
module tb_btn_conditioner;

  logic CLK;
  logic RST_N;

  btn_conditioner_if bi ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .btn  (bi.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        in;
    int unsigned len;
    int unsigned n_press;
    int unsigned n_release;
    int unsigned n_repeat;
    int unsigned n_level;
    int unsigned n_held;
  } seg_t;

  seg_t tbl[$];
  int   n_vec;
  int   n_err;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Drive the pin, let one rising edge sample it, then look at the outputs.
  task automatic step(input logic v);
    bi.BTN_IN = v;
    @(posedge CLK);
    #1;
    chk("press_and_release_same_cycle", int'(bi.BTN_PRESS & bi.BTN_RELEASE), 0);
    chk("press_and_repeat_same_cycle",  int'(bi.BTN_PRESS & bi.BTN_REPEAT),  0);
  endtask

  task automatic chk_outs(input string nm, input logic lv, input logic pr,
                          input logic rl, input logic hd, input logic rp);
    chk({nm, "_level"},   int'(bi.BTN_LEVEL),   int'(lv));
    chk({nm, "_press"},   int'(bi.BTN_PRESS),   int'(pr));
    chk({nm, "_release"}, int'(bi.BTN_RELEASE), int'(rl));
    chk({nm, "_held"},    int'(bi.BTN_HELD),    int'(hd));
    chk({nm, "_repeat"},  int'(bi.BTN_REPEAT),  int'(rp));
  endtask

  initial begin
    int unsigned c_press, c_rel, c_rep, c_lvl, c_held;
    logic v;
    n_vec = 0;
    n_err = 0;

    // Segment table: pin value, length, expected pulse and high-cycle counts.
    tbl.push_back('{1'b0, 5, 0, 0, 0, 0, 0});
    for (int k = 0; k < 5; k++) begin
      tbl.push_back('{1'b1, 3, 0, 0, 0, 0, 0});
      tbl.push_back('{1'b0, 1, 0, 0, 0, 0, 0});
    end
    tbl.push_back('{1'b0, 6, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 15, 1, 0, 0, 9, 0});   // clean press
    tbl.push_back('{1'b0, 10, 0, 1, 0, 6, 0});   // clean release
    tbl.push_back('{1'b1, 62, 1, 0, 5, 56, 36}); // press into hold/repeat
    tbl.push_back('{1'b0, 10, 0, 1, 0, 6, 6});   // release from held

    // Asynchronous reset: outputs low before any clock edge.
    RST_N     = 1'b0;
    bi.BTN_IN = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      c_press = 0; c_rel = 0; c_rep = 0; c_lvl = 0; c_held = 0;
      for (int e = 0; e < int'(tbl[i].len); e++) begin
        step(tbl[i].in);
        c_press += int'(bi.BTN_PRESS);
        c_rel   += int'(bi.BTN_RELEASE);
        c_rep   += int'(bi.BTN_REPEAT);
        c_lvl   += int'(bi.BTN_LEVEL);
        c_held  += int'(bi.BTN_HELD);
      end
      chk($sformatf("seg%0d_press_count", i),   int'(c_press), int'(tbl[i].n_press));
      chk($sformatf("seg%0d_release_count", i), int'(c_rel),   int'(tbl[i].n_release));
      chk($sformatf("seg%0d_repeat_count", i),  int'(c_rep),   int'(tbl[i].n_repeat));
      chk($sformatf("seg%0d_level_cycles", i),  int'(c_lvl),   int'(tbl[i].n_level));
      chk($sformatf("seg%0d_held_cycles", i),   int'(c_held),  int'(tbl[i].n_held));
    end

    // Exact edges: press at 6, held+repeat at 26, 2-cycle low glitch at 27-28
    // returns to HELD at 31 so the next repeat is 39; release edge 46.
    for (int e = 0; e < 51; e++) begin
      v = (e == 27 || e == 28 || e >= 40) ? 1'b0 : 1'b1;
      step(v);
      if (e < 40)
        chk_outs($sformatf("hold_e%0d", e), e >= 6, e == 6, 1'b0, e >= 26,
                 (e == 26 || e == 39));
      else
        chk_outs($sformatf("rel_e%0d", e), e < 46, 1'b0, e == 46, e < 46, 1'b0);
    end

    // Reset while PRESSED, button kept down through and after reset.
    for (int e = 0; e < 10; e++) step(1'b1);
    chk_outs("pre_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    chk_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    step(1'b1);
    chk_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step(1'b1);
      chk_outs($sformatf("post_reset_e%0d", e), e >= 6, e == 6, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions one raw push-button from the board pin before it reaches `top`'s `BTN_CTRL` input.
- Synchronises the pin to `CLK`, then debounces it.
- Produces a clean level plus single-cycle press, release and auto-repeat pulses. Downstream control logic uses these for single-step and run control of the RISC-V core.
- One instance per button, placed in the board top level, upstream of `top`.

Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000, cycles input must be stable to accept a change (10 ms at 100 MHz). Minimum 2.
- `HOLD_CYCLES`, 50_000_000, cycles pressed before entering held/auto-repeat. Minimum 2.
- `REPEAT_CYCLES`, 10_000_000, period of `BTN_REPEAT` pulses while held. Minimum 2.

Ports:
- `CLK` input 1: system clock, all logic on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `BTN_IN` input 1: raw, asynchronous, bouncing button pin; high = pressed.
- `BTN_LEVEL` output 1: debounced level; drives `top.BTN_CTRL`.
- `BTN_PRESS` output 1: one-cycle pulse on an accepted press.
- `BTN_RELEASE` output 1: one-cycle pulse on an accepted release.
- `BTN_HELD` output 1: high while in the held/auto-repeat region.
- `BTN_REPEAT` output 1: one-cycle pulse on entering held, then every `REPEAT_CYCLES` while held.

Behaviour:
- Reset (`RST_N`=0, asynchronous):
  - Both synchroniser FFs = 0, state = IDLE, counter = 0, held flag = 0.
  - All outputs = 0 immediately, with no clock required.
  - Reset mid-operation discards all progress. No release pulse is emitted.
- Synchroniser: 2 FFs, `s` = second FF output. `BTN_IN` is never used directly by the FSM.
- Counter:
  - Single counter, width `$clog2(max(DEBOUNCE,HOLD,REPEAT))+1`.
  - Cleared to 0 on every state entry; increments every cycle in a timing state.
- Timing rule: a timed transition fires on the edge where counter == N-1, i.e. N edges after the entry edge.
- All outputs are registered and take their new value on the transition edge. Pulses last exactly one cycle.
- States:
  - IDLE: `BTN_LEVEL`=0, `BTN_HELD`=0.
    - `s`=1 → DB_PRESS.
  - DB_PRESS: `BTN_LEVEL`=0.
    - `s`=0 → IDLE, no pulse.
    - Counter hits `DEBOUNCE_CYCLES`-1 with `s`=1 → PRESSED; `BTN_LEVEL`←1, `BTN_PRESS` pulses.
  - PRESSED:
    - `s`=0 → DB_RELEASE.
    - Counter hits `HOLD_CYCLES`-1 → HELD; held flag←1, `BTN_HELD`←1, `BTN_REPEAT` pulses.
  - HELD:
    - `s`=0 → DB_RELEASE.
    - Counter hits `REPEAT_CYCLES`-1 → stay in HELD, counter←0, `BTN_REPEAT` pulses.
  - DB_RELEASE: `BTN_LEVEL` stays 1, `BTN_HELD` holds its value.
    - `s`=1 → back to HELD if held flag = 1, else PRESSED. Counter restarts, so hold/repeat timing restarts.
    - Counter hits `DEBOUNCE_CYCLES`-1 with `s`=0 → IDLE; `BTN_LEVEL`←0, `BTN_HELD`←0, held flag←0, `BTN_RELEASE` pulses.
- Latency:
  - Edge 0 is the first edge sampling `BTN_IN`=1 (or 0 for a release), with the input stable afterwards.
  - `BTN_PRESS` / `BTN_RELEASE` is asserted after edge `DEBOUNCE_CYCLES`+2: two synchroniser edges, one detect edge, then `DEBOUNCE_CYCLES` counting edges.
- Pulse exclusivity:
  - `BTN_PRESS` and `BTN_RELEASE` are never high in the same cycle.
  - `BTN_PRESS` is never coincident with `BTN_REPEAT`.
- Button held through reset: after `RST_N` rises, the button is treated as a fresh press. `BTN_PRESS` fires per the latency rule, with edge 0 = first edge after deassertion.
- Glitch rejection: any excursion shorter than `DEBOUNCE_CYCLES` of synchronised samples causes no output change.

Test Plan (`DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=8, 10 ns clock):
- Clean press: `BTN_IN` 0→1, held 15 cycles → `BTN_PRESS` high exactly one cycle after edge 6. `BTN_LEVEL`=1 from that edge. No other pulses.
- Press bounce: `BTN_IN` toggles high 3 cycles / low 1, repeated 5×, then low → `BTN_PRESS`=0 and `BTN_LEVEL`=0 throughout.
- Clean release: after an accepted press, `BTN_IN` 1→0 → `BTN_RELEASE` one cycle after edge 6 of the release. `BTN_LEVEL`=0 from that edge. `BTN_HELD` stays 0.
- Hold/repeat: hold pressed 60 cycles after `BTN_PRESS` →
  - `BTN_HELD` rises and `BTN_REPEAT` pulses 20 cycles after `BTN_PRESS`.
  - Further `BTN_REPEAT` at +28, +36, +44, +52.
  - On release, `BTN_RELEASE` fires and `BTN_HELD` falls on the same edge.
- Release glitch while held: in HELD, `BTN_IN` low 2 cycles then high → no `BTN_RELEASE`. `BTN_HELD`/`BTN_LEVEL` stay 1. Next `BTN_REPEAT` is 8 cycles after the return to HELD.
- Reset mid-press: in PRESSED, pull `RST_N` low between edges → all outputs 0 immediately. Release reset with `BTN_IN`=1 → `BTN_PRESS` one cycle after edge 6, counted from the first edge after deassertion.
